// File: rtl/imm_share_arb_pkg.sv
// Shared types and opcode constants for the immediate-generator arbiter.
package imm_pkg;

    // Immediate format reported with each response.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5
    } imm_type_e;

    // Major opcodes (instr[6:0]) that carry an immediate.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Map an opcode to its immediate format; unknown opcodes carry no immediate.
    function automatic imm_type_e classify_opcode(input logic [6:0] opc);
        imm_type_e t;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = I;
            OPC_STORE:                      t = S;
            OPC_BRANCH:                     t = B;
            OPC_LUI, OPC_AUIPC:             t = U;
            OPC_JAL:                        t = J;
            default:                        t = NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_share_arb_immgen.sv
// immgen: builds all five sign-extended immediate formats from one
// instruction word. Only instr[31:7] is needed; the opcode is decoded
// by the caller.
module immgen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/imm_share_arb.sv
// imm_share_arb: shares one immediate generator between decode (req0) and
// the early branch-target unit (req1). One grant per cycle into a single
// registered response slot with valid/ready handshake.
// Build option: IMM_SHARE_ARB_FIXED_PRIO_EN selects fixed priority (req0
// always wins a conflict) instead of the default round-robin pointer.
module imm_share_arb
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic [31:0] req0_instr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_instr,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_imm,
    output imm_type_e   rsp_type,
    output logic        rsp_id
);

    logic        slot_free_s;
    logic        grant_en_s;
    logic        gnt0_s;
    logic        gnt1_s;
    logic [31:0] sel_instr_s;
    imm_type_e   sel_type_s;
    logic [31:0] sel_imm_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
`ifndef IMM_SHARE_ARB_FIXED_PRIO_EN
    logic        prio_r;
`endif

    // rst_n gates the grant so readies drop the moment reset asserts,
    // even though the slot reads as empty during reset.
    assign slot_free_s = !rsp_valid || rsp_ready;
    assign grant_en_s  = rst_n && slot_free_s && !flush;

    // Grant at most one valid requester when the slot can take a result.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (grant_en_s) begin
            if (req0_valid && req1_valid) begin
`ifdef IMM_SHARE_ARB_FIXED_PRIO_EN
                gnt0_s = 1'b1;
                gnt1_s = 1'b0;
`else
                gnt0_s = !prio_r;
                gnt1_s = prio_r;
`endif
            end else begin
                gnt0_s = req0_valid;
                gnt1_s = req1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready  = gnt0_s;
    assign req1_ready  = gnt1_s;
    assign sel_instr_s = gnt1_s ? req1_instr : req0_instr;
    assign sel_type_s  = classify_opcode(sel_instr_s[6:0]);

    immgen u_immgen (
        .instr (sel_instr_s[31:7]),
        .imm_i (imm_i_s),
        .imm_s (imm_s_s),
        .imm_b (imm_b_s),
        .imm_u (imm_u_s),
        .imm_j (imm_j_s)
    );

    // Pick the immediate matching the decoded format; zero when none applies.
    always_comb begin
        sel_imm_s = 32'h0000_0000;
        case (sel_type_s)
            I:       sel_imm_s = imm_i_s;
            S:       sel_imm_s = imm_s_s;
            B:       sel_imm_s = imm_b_s;
            U:       sel_imm_s = imm_u_s;
            J:       sel_imm_s = imm_j_s;
            default: sel_imm_s = 32'h0000_0000;
        endcase
    end

    // Response slot: flush discards, a grant loads, acceptance empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_imm   <= 32'h0000_0000;
            rsp_type  <= NONE;
            rsp_id    <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (gnt0_s || gnt1_s) begin
            rsp_valid <= 1'b1;
            rsp_imm   <= sel_imm_s;
            rsp_type  <= sel_type_s;
            rsp_id    <= gnt1_s;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

`ifndef IMM_SHARE_ARB_FIXED_PRIO_EN
    // Round-robin pointer: favour the other requester after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (gnt0_s) begin
            prio_r <= 1'b1;
        end else if (gnt1_s) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end
`endif

endmodule

// File: tb/tb_imm_share_arb.sv
// Scoreboard bench for imm_share_arb: the driver predicts grants and pushes
// expected responses; a monitor compares the response slot on each negedge.
module tb_imm_share_arb;
    import imm_pkg::*;

    typedef struct {
        logic [31:0] imm;
        imm_type_e   typ;
        logic        id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req0_valid;
    logic [31:0] req0_instr;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_instr;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_imm;
    imm_type_e   rsp_type;
    logic        rsp_id;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_valid = 1'b0;
    logic m_prio  = 1'b0;

    imm_share_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_instr (req0_instr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_instr (req1_instr),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_imm    (rsp_imm),
        .rsp_type   (rsp_type),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Hand-computed immediates for the directed instruction words.
    function automatic exp_t ref_of(input logic [31:0] instr, input logic id);
        exp_t e;
        e.id = id;
        case (instr)
            32'hFFF00093: begin e.imm = 32'hFFFF_FFFF; e.typ = I;    end
            32'h00500113: begin e.imm = 32'h0000_0005; e.typ = I;    end
            32'hFE000EE3: begin e.imm = 32'hFFFF_FFFC; e.typ = B;    end
            32'h000010B7: begin e.imm = 32'h0000_1000; e.typ = U;    end
            32'hFE112E23: begin e.imm = 32'hFFFF_FFFC; e.typ = S;    end
            32'h0080006F: begin e.imm = 32'h0000_0008; e.typ = J;    end
            32'h00000033: begin e.imm = 32'h0000_0000; e.typ = NONE; end
            default:      begin e.imm = 32'h0000_0000; e.typ = NONE; end
        endcase
        return e;
    endfunction

    // One cycle of stimulus: drive, predict and check readies, update model.
    task automatic step(input logic v0, input logic [31:0] i0, input logic v1,
                        input logic [31:0] i1, input logic rr, input logic fl);
        logic sf;
        logic e0;
        logic e1;
        req0_valid = v0; req0_instr = i0;
        req1_valid = v1; req1_instr = i1;
        rsp_ready  = rr; flush      = fl;
        @(negedge clk);
        sf = !m_valid || rr;
        e0 = 1'b0;
        e1 = 1'b0;
        if (sf && !fl) begin
            if (v0 && v1) begin
`ifdef IMM_SHARE_ARB_FIXED_PRIO_EN
                e0 = 1'b1;
`else
                if (m_prio) e1 = 1'b1;
                else        e0 = 1'b1;
`endif
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        @(posedge clk);
        if (fl) begin
            if (m_valid && q.size() > 0) q.delete(0);
            m_valid = 1'b0;
        end else if (e0 || e1) begin
            q.push_back(ref_of(e0 ? i0 : i1, e1));
            m_valid = 1'b1;
            m_prio  = e0;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    // Monitor: slot validity every cycle; contents whenever valid; pop on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got a response, expected none at %0t", $time);
                end else begin
                    check("rsp_imm", rsp_imm, q[0].imm);
                    check("rsp_type", {29'd0, rsp_type}, {29'd0, q[0].typ});
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
                    if (rsp_ready) q.delete(0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_instr = 32'h0; req1_valid = 1'b0; req1_instr = 32'h0;
        #22;
        rst_n = 1'b1;
        #1;
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_imm", rsp_imm, 32'd0);
        check("reset_type", {29'd0, rsp_type}, {29'd0, NONE});
        check("reset_id", {31'd0, rsp_id}, 32'd0);
        @(posedge clk); #1;

        // Contention: ids alternate 0,1,0,1 under round-robin.
        for (int k = 0; k < 4; k++) step(1'b1, 32'hFE000EE3, 1'b1, 32'h000010B7, 1'b1, 1'b0);
        // Single requester: addi x1,x0,-1.
        step(1'b1, 32'hFFF00093, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: load slot, stall 3 cycles with both valid, then release.
        step(1'b1, 32'hFE112E23, 1'b1, 32'h0080006F, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 32'hFE112E23, 1'b1, 32'h0080006F, 1'b0, 1'b0);
        step(1'b1, 32'hFE112E23, 1'b1, 32'h0080006F, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a full slot and req1 waiting; pointer must survive.
        step(1'b1, 32'h00500113, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0080006F, 1'b0, 1'b1);
        step(1'b1, 32'h00000033, 1'b1, 32'h000010B7, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h000010B7, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-traffic.
        step(1'b1, 32'hFFF00093, 1'b1, 32'h000010B7, 1'b0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        q.delete();
        m_valid = 1'b0;
        m_prio  = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("rst_rel_imm", rsp_imm, 32'd0);
        check("rst_rel_type", {29'd0, rsp_type}, {29'd0, NONE});
        @(posedge clk); #1;

        // Re-presented request after reset, then an unsupported opcode.
        step(1'b1, 32'hFFF00093, 1'b1, 32'h000010B7, 1'b1, 1'b0);
        step(1'b1, 32'h00000033, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_share_arb.md
# imm_share_arb

Arbiter that shares one immediate generator between two requesters: decode (requester 0) and the fetch-side early branch-target unit (requester 1). Each cycle it grants at most one valid request, classifies the granted instruction's opcode into an immediate format, and selects the matching sign-extended immediate. The result goes into a single registered response slot with a valid/ready handshake. Sits between fetch/decode and the execute-stage operand path.

## Interface
- No parameters. The data width is fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; discards the response slot.
- req0_valid  in  1  requester 0 has an instruction.
- req0_instr  in  32  requester 0 instruction word.
- req0_ready  out  1  requester 0 granted this cycle.
- req1_valid  in  1  requester 1 has an instruction.
- req1_instr  in  32  requester 1 instruction word.
- req1_ready  out  1  requester 1 granted this cycle.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_imm  out  32  sign-extended immediate.
- rsp_type  out  3  immediate format (package enum).
- rsp_id  out  1  index of the granted requester.

## Operation
- Transfer rule (both sides): a transfer occurs when valid && ready are both high on a clock edge.
  - Requesters keep instr stable while valid && !ready.
  - req*_ready may depend combinationally on req*_valid and rsp_ready.
- Slot free: `slot_free = !rsp_valid || rsp_ready`.
- Grant: issued only when slot_free && !flush. Otherwise both req*_ready are 0.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the round-robin pointer `prio` is granted.
  - At most one ready is high per cycle.
- Round-robin pointer `prio`:
  - Reset value 0.
  - After any grant to requester k, `prio` becomes 1-k.
  - It is unchanged on cycles with no grant.
- Opcode classification (instr[6:0]):
  - I: 0000011, 0010011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Any other opcode: NONE, with rsp_imm = 0.
- Immediate formats (all sign bits taken from instr[31]):
  - I: sign-extended instr[31:20].
  - S: sign-extended {instr[31:25], instr[11:7]}.
  - B: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Response slot: on a grant it loads imm, type and id, and sets rsp_valid = 1.
  - Slot accepted and no new grant: rsp_valid clears.
  - Slot not accepted: contents hold unchanged.
- Flush: rsp_valid clears on the next edge, with no grant in the flush cycle.
  - Flush wins over rsp_ready and over any request.
  - `prio` is unchanged by flush.
- Reset (asynchronous):
  - rsp_valid = 0, rsp_imm = 0, rsp_type = NONE, rsp_id = 0, prio = 0.
  - req*_ready go low immediately.
  - A request in flight when reset asserts is dropped; requesters re-present it after reset.

## Timing
- Latency: grant in cycle N → rsp_valid high in cycle N+1.
- Throughput: one result per cycle while rsp_ready is held high.
- Back-to-back: a grant and the consumption of the previous response happen in the same cycle without a bubble.
- No combinational path from req*_instr to any output; rsp_* are all registered.
- The only combinational paths are req*_valid / rsp_ready / flush → req*_ready.

## Configuration
- Macro: `IMM_SHARE_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority. Requester 0 wins every conflict and `prio` is not implemented.
- Undefined (default): round-robin as described in Operation.

## Structure
- Package `imm_pkg`:
  - `imm_type_e` enum, 3 bits: NONE=0, I=1, S=2, B=3, U=4, J=5.
  - Opcode localparams for the classification above.
- Sub-module: instantiate the existing `immgen` block for the five immediate formats.
- Format classification and selection, the arbiter and the response register live in imm_share_arb.

## Test plan
- Reset: rst_n=0 mid-traffic → req0_ready=req1_ready=0 at once; rsp_valid=0, rsp_imm=0, rsp_type=NONE after release.
- Single requester: req0 0xFFF00093 (addi x1,x0,-1), rsp_ready=1 → next cycle rsp_valid=1, rsp_imm=0xFFFFFFFF, rsp_type=I, rsp_id=0.
- Contention: both valid continuously; req0 0xFE000EE3, req1 0x000010B7; rsp_ready=1 →
  - rsp_id sequence 0,1,0,1.
  - 0xFE000EE3 gives imm 0xFFFFFFFC, type B.
  - 0x000010B7 gives imm 0x00001000, type U.
- Backpressure: rsp_ready=0 for 3 cycles with both requesters valid →
  - Both ready stay low; rsp_* hold unchanged; prio holds.
  - On release, the next grant goes to the pointed requester in the same cycle.
- Flush: flush=1 while rsp_valid=1 and req1 valid → no grant that cycle, rsp_valid=0 next cycle, prio unchanged.
- Unsupported opcode and macro build:
  - req0 0x00000033 (add) → type NONE, imm 0.
  - With `IMM_SHARE_ARB_FIXED_PRIO_EN` and both requesters always valid → rsp_id is always 0.
